// File: rtl/button_sequence_player_pkg.sv
// Shared definitions for the button sequence player and anything that talks to it.
// Holds the active-low button symbol codes, the player state encoding and the
// pattern lookup so the recognizer bench drives exactly the same codes.
package button_sequence_player_pkg;

  // Active-low DE0 button levels: [2]=A, [1]=B, [0]=C.
  localparam logic [2:0] SYM_A    = 3'b011;
  localparam logic [2:0] SYM_B    = 3'b101;
  localparam logic [2:0] SYM_C    = 3'b110;
  localparam logic [2:0] SYM_NONE = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StRelease,
    StDone
  } state_e;

  // sel=0 -> A,B,B,A,C (accepted by the recognizer); sel=1 -> A,B,B,A,B (rejected).
  function automatic logic [2:0] pattern_sym(input logic sel, input logic [2:0] idx);
    case (idx)
      3'd0, 3'd3: return SYM_A;
      3'd1, 3'd2: return SYM_B;
      3'd4:       return sel ? SYM_B : SYM_C;
      default:    return SYM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_sequence_player.sv
// Replays a 5-symbol button sequence as active-low button levels, one run per
// rising edge of start.
//   Clock  : system clock, rising edge
//   Resetn : asynchronous active-low reset
//   start  : level request; a rising edge seen while idle starts one run
//   sel    : pattern select (0 = ABBAC, 1 = ABBAB), latched when a run starts
//   Button : registered active-low buttons [2]=A, [1]=B, [0]=C
//   busy   : high while a sequence is playing
//   done   : one-cycle pulse after the last gap
//   step   : index of the current symbol, 0 when idle
module button_sequence_player
  import button_sequence_player_pkg::*;
#(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 4,
  parameter int unsigned LEN  = 5
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       start,
  input  logic       sel,
  output logic [2:0] Button,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  localparam int unsigned MaxCnt = (HOLD > GAP) ? HOLD : GAP;
  // A count of 1 still needs one bit; the counter only ever loads 0 then.
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] HoldInit = CntW'(HOLD - 1);
  localparam logic [CntW-1:0] GapInit  = CntW'(GAP - 1);
  localparam logic [2:0]      LastIdx  = 3'(LEN - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            start_q;
  logic            sel_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
      sel_q   <= 1'b0;
      Button  <= SYM_NONE;
      busy    <= 1'b0;
      done    <= 1'b0;
      step    <= 3'd0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state_q)
        StIdle: begin
          // Edges outside idle are dropped, so a held start yields one run.
          if (start && !start_q) begin
            state_q <= StPress;
            cnt_q   <= HoldInit;
            sel_q   <= sel;
            step    <= 3'd0;
            Button  <= pattern_sym(sel, 3'd0);
            busy    <= 1'b1;
          end
        end
        StPress: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            state_q <= StRelease;
            cnt_q   <= GapInit;
            Button  <= SYM_NONE;
          end
        end
        StRelease: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (step != LastIdx) begin
            state_q <= StPress;
            cnt_q   <= HoldInit;
            step    <= step + 3'd1;
            Button  <= pattern_sym(sel_q, step + 3'd1);
          end else begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          step    <= 3'd0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_button_sequence_player.sv
// Bench for button_sequence_player: two instances (HOLD=2/GAP=3 and HOLD=1/GAP=1)
// share stimulus. A per-instance queue of expected per-edge outputs is filled
// from the timing formula when a run is requested and drained after every edge;
// with an empty queue the outputs must be idle. Spot checks from a table are
// applied to captured traces afterwards.
module tb_button_sequence_player;

  typedef struct {
    logic [2:0] btn;
    logic       busy;
    logic       done;
    logic [2:0] step;
    bit         chk_step;
  } exp_t;

  typedef struct {
    int         dut;
    int         run;
    int         edge_n;
    logic [2:0] btn;
    logic       busy;
    logic       done;
  } vec_t;

  localparam int NEdge = 28;

  logic       Clock;
  logic       Resetn;
  logic       start;
  logic       sel;
  logic [2:0] button0, button1, step0, step1;
  logic       busy0, busy1, done0, done1;

  int   checks;
  int   errors;
  bit   mon_en;
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[$];

  logic [2:0] tr_btn  [2][3][NEdge];
  logic       tr_busy [2][3][NEdge];
  logic       tr_done [2][3][NEdge];

  button_sequence_player #(.HOLD(2), .GAP(3), .LEN(5)) dut0 (
    .Clock (Clock),
    .Resetn(Resetn),
    .start (start),
    .sel   (sel),
    .Button(button0),
    .busy  (busy0),
    .done  (done0),
    .step  (step0)
  );

  button_sequence_player #(.HOLD(1), .GAP(1), .LEN(5)) dut1 (
    .Clock (Clock),
    .Resetn(Resetn),
    .start (start),
    .sel   (sel),
    .Button(button1),
    .busy  (busy1),
    .done  (done1),
    .step  (step1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [2:0] exp_sym(input bit s, input int i);
    case (i)
      0, 3:    return 3'b011;
      1, 2:    return 3'b101;
      4:       return s ? 3'b101 : 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.btn = 3'b111; e.busy = 1'b0; e.done = 1'b0; e.step = 3'd0; e.chk_step = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic [2:0] b, input logic bu,
                     input logic d, input logic [2:0] s);
    checks++;
    if (b !== e.btn || bu !== e.busy || d !== e.done || (e.chk_step && s !== e.step)) begin
      errors++;
      $display("FAIL %s @%0t: got Button=%b busy=%b done=%b step=%0d, want Button=%b busy=%b done=%b step=%0d",
               nm, $time, b, bu, d, s, e.btn, e.busy, e.done, e.step);
    end
  endtask

  // Expected outputs after edges 0 .. LEN*(HOLD+GAP)+1 of one run.
  task automatic push_run(input int which, input bit s);
    int h = (which == 0) ? 2 : 1;
    int g = (which == 0) ? 3 : 1;
    int p = h + g;
    for (int t = 0; t <= 5 * p + 1; t++) begin
      exp_t e;
      if (t < 5 * p) begin
        e.btn = ((t % p) < h) ? exp_sym(s, t / p) : 3'b111;
        e.busy = 1'b1; e.done = 1'b0; e.step = 3'(t / p); e.chk_step = 1'b1;
      end else if (t == 5 * p) begin
        e.btn = 3'b111; e.busy = 1'b0; e.done = 1'b1; e.step = 3'd0; e.chk_step = 1'b0;
      end else begin
        e = idle_exp();
      end
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (mon_en) begin
      e = (q0.size() > 0) ? q0.pop_front() : idle_exp();
      cmp("sb_dut0", e, button0, busy0, done0, step0);
      e = (q1.size() > 0) ? q1.pop_front() : idle_exp();
      cmp("sb_dut1", e, button1, busy1, done1, step1);
    end
  end

  // One pulsed run; optional sel toggle and a second start edge mid-run.
  task automatic run_seq(input bit s, input int run_id, input int toggle_edge, input int reedge);
    @(negedge Clock);
    sel = s;
    start = 1'b1;
    push_run(0, s);
    push_run(1, s);
    for (int e = 0; e < NEdge; e++) begin
      @(posedge Clock);
      #1;
      if (run_id >= 0) begin
        tr_btn[0][run_id][e]  = button0;
        tr_busy[0][run_id][e] = busy0;
        tr_done[0][run_id][e] = done0;
        tr_btn[1][run_id][e]  = button1;
        tr_busy[1][run_id][e] = busy1;
        tr_done[1][run_id][e] = done1;
      end
      if (e == 0) start = 1'b0;
      if (e == toggle_edge) sel = ~sel;
      if (e == reedge - 1) start = 1'b1;
      if (e == reedge) start = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    Resetn = 1'b0;
    start  = 1'b0;
    sel    = 1'b0;

    // dut, run, edge, Button, busy, done
    tbl.push_back('{0, 0, 0,  3'b011, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 1,  3'b011, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 2,  3'b111, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 4,  3'b111, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 5,  3'b101, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 7,  3'b111, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 10, 3'b101, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 11, 3'b101, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 15, 3'b011, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 16, 3'b011, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 20, 3'b110, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 21, 3'b110, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 24, 3'b111, 1'b1, 1'b0});
    tbl.push_back('{0, 0, 25, 3'b111, 1'b0, 1'b1});
    tbl.push_back('{0, 0, 26, 3'b111, 1'b0, 1'b0});
    tbl.push_back('{0, 1, 20, 3'b101, 1'b1, 1'b0});
    tbl.push_back('{0, 1, 21, 3'b101, 1'b1, 1'b0});
    tbl.push_back('{0, 2, 20, 3'b110, 1'b1, 1'b0});
    tbl.push_back('{0, 2, 21, 3'b110, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 0,  3'b011, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 1,  3'b111, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 2,  3'b101, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 4,  3'b101, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 6,  3'b011, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 8,  3'b110, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 9,  3'b111, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 10, 3'b111, 1'b0, 1'b1});
    tbl.push_back('{1, 0, 11, 3'b111, 1'b0, 1'b0});
    tbl.push_back('{1, 1, 8,  3'b101, 1'b1, 1'b0});

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    cmp("reset_dut0", idle_exp(), button0, busy0, done0, step0);
    cmp("reset_dut1", idle_exp(), button1, busy1, done1, step1);
    @(negedge Clock);
    Resetn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge Clock);

    run_seq(1'b0, 0, -1, -1);   // ABBAC
    run_seq(1'b1, 1, -1, -1);   // ABBAB
    run_seq(1'b0, 2, 3, -1);    // sel toggled after edge 3
    run_seq(1'b0, -1, -1, 8);   // second rising edge at edge 8 is dropped

    // start held high for 40 cycles gives one run only
    @(negedge Clock);
    sel = 1'b0;
    start = 1'b1;
    push_run(0, 1'b0);
    push_run(1, 1'b0);
    repeat (40) @(posedge Clock);
    @(negedge Clock);
    start = 1'b0;
    repeat (3) @(posedge Clock);

    // Asynchronous reset between edges 11 and 12 (dut0 pressing symbol 2)
    @(negedge Clock);
    start = 1'b1;
    push_run(0, 1'b0);
    push_run(1, 1'b0);
    @(posedge Clock);
    #1;
    start = 1'b0;
    repeat (11) @(posedge Clock);
    #3;
    mon_en = 1'b0;
    q0.delete();
    q1.delete();
    Resetn = 1'b0;
    #1;
    cmp("midrun_reset_dut0", idle_exp(), button0, busy0, done0, step0);
    cmp("midrun_reset_dut1", idle_exp(), button1, busy1, done1, step1);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    mon_en = 1'b1;
    repeat (30) @(posedge Clock);  // no done pulse may appear
    run_seq(1'b0, -1, -1, -1);      // full replay from index 0

    mon_en = 1'b0;
    foreach (tbl[k]) begin
      exp_t e;
      e.btn = tbl[k].btn; e.busy = tbl[k].busy; e.done = tbl[k].done;
      e.step = 3'd0; e.chk_step = 1'b0;
      cmp($sformatf("tbl%0d_dut%0d_run%0d_edge%0d", k, tbl[k].dut, tbl[k].run, tbl[k].edge_n), e,
          tr_btn[tbl[k].dut][tbl[k].run][tbl[k].edge_n],
          tr_busy[tbl[k].dut][tbl[k].run][tbl[k].edge_n],
          tr_done[tbl[k].dut][tbl[k].run][tbl[k].edge_n], 3'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
